// File: rtl/ysyx_22040386_mem_stage.sv
// Memory-access stage: runs loads/stores against a request/response data port; non-memory ops pass through.
// Latency: 1 cycle for non-memory ops, 2 edges + memory handshakes (3 cycles minimum) for loads, 2+ for stores.
// Backpressure: o_MEM_ready is low whenever a memory access is outstanding (REQ or WAIT).
//
// Ports: EX bundle (i_MEM_*, valid/ready), data-memory port (o_dmem_* / i_dmem_*),
// registered write-back bundle (o_WB_*, o_WB_valid is a one-cycle pulse).
// Optional: define YSYX_22040386_MEM_MISALIGN_CHK_EN to add o_WB_misalign and suppress
// misaligned accesses; otherwise misaligned accesses are issued with a truncated byte mask.
// Reset: rst_n is synchronous and active-low.
module ysyx_22040386_mem_stage #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_MEM_valid,
    output logic            o_MEM_ready,
    input  logic [XLEN-1:0] i_MEM_ALUresult,
    input  logic [XLEN-1:0] i_MEM_reg_wr_data,
    input  logic [XLEN-1:0] i_MEM_mem_wr_data,
    input  logic [2:0]      i_MEM_FUNCT3,
    input  logic            i_MEM_MemRead,
    input  logic            i_MEM_MemWrite,
    input  logic            i_MEM_RegWrite,
    input  logic [4:0]      i_MEM_reg_wr_addr,
    input  logic [XLEN-1:0] i_MEM_pc,
    output logic            o_dmem_req,
    input  logic            i_dmem_ready,
    output logic            o_dmem_we,
    output logic [XLEN-1:0] o_dmem_addr,
    output logic [XLEN-1:0] o_dmem_wdata,
    output logic [7:0]      o_dmem_wmask,
    input  logic            i_dmem_rvalid,
    input  logic [XLEN-1:0] i_dmem_rdata,
`ifdef YSYX_22040386_MEM_MISALIGN_CHK_EN
    output logic            o_WB_misalign,
`endif
    output logic            o_WB_valid,
    output logic            o_WB_RegWrite,
    output logic [4:0]      o_WB_reg_wr_addr,
    output logic [XLEN-1:0] o_WB_reg_wr_data,
    output logic [XLEN-1:0] o_WB_pc
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t state, state_nxt;

    // Access captured at accept time; held while REQ/WAIT are in progress.
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic [2:0]      f3_q;
    logic            is_load_q;
    logic            rw_q;
    logic [4:0]      rd_q;
    logic [XLEN-1:0] pc_q;

    logic            accept;
    logic            is_mem_in;
    logic            mis_in;
    logic [2:0]      off_q;
    logic [7:0]      base_mask;

    assign accept    = i_MEM_valid && o_MEM_ready;
    assign is_mem_in = i_MEM_MemRead || i_MEM_MemWrite;
    assign off_q     = addr_q[2:0];

`ifdef YSYX_22040386_MEM_MISALIGN_CHK_EN
    // Natural alignment by access size; funct3 111 has no defined size and is never flagged.
    always_comb begin
        mis_in = 1'b0;
        if (is_mem_in && (i_MEM_FUNCT3 != 3'b111)) begin
            case (i_MEM_FUNCT3[1:0])
                2'b01:   mis_in = i_MEM_ALUresult[0];
                2'b10:   mis_in = |i_MEM_ALUresult[1:0];
                2'b11:   mis_in = |i_MEM_ALUresult[2:0];
                default: mis_in = 1'b0;
            endcase
        end
    end
`else
    assign mis_in = 1'b0;
`endif

    // Shift the returned word down to the access offset, then size/sign-extend.
    function automatic logic [63:0] load_extract(input logic [63:0] rdata,
                                                 input logic [2:0]  off,
                                                 input logic [2:0]  f3);
        logic [63:0] s;
        s = rdata >> {off, 3'b000};
        case (f3)
            3'b000:  load_extract = {{56{s[7]}},  s[7:0]};
            3'b001:  load_extract = {{48{s[15]}}, s[15:0]};
            3'b010:  load_extract = {{32{s[31]}}, s[31:0]};
            3'b011:  load_extract = s;
            3'b100:  load_extract = {56'b0, s[7:0]};
            3'b101:  load_extract = {48'b0, s[15:0]};
            3'b110:  load_extract = {32'b0, s[31:0]};
            default: load_extract = 64'b0;
        endcase
    endfunction

    always_comb begin
        case (f3_q[1:0])
            2'b00:   base_mask = 8'h01;
            2'b01:   base_mask = 8'h03;
            2'b10:   base_mask = 8'h0F;
            default: base_mask = 8'hFF;
        endcase
    end

    // Next state and handshake outputs. The dmem bus is driven only in REQ so it stays quiet otherwise.
    always_comb begin
        state_nxt    = state;
        o_MEM_ready  = 1'b0;
        o_dmem_req   = 1'b0;
        o_dmem_we    = 1'b0;
        o_dmem_addr  = '0;
        o_dmem_wdata = '0;
        o_dmem_wmask = 8'h00;
        case (state)
            IDLE: begin
                o_MEM_ready = 1'b1;
                if (accept && is_mem_in && !mis_in) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                o_dmem_req   = 1'b1;
                o_dmem_we    = !is_load_q;
                o_dmem_addr  = {addr_q[XLEN-1:3], 3'b000};
                o_dmem_wdata = wdata_q << {off_q, 3'b000};
                // 8-bit result: bytes shifted past lane 7 are dropped.
                o_dmem_wmask = is_load_q ? 8'h00 : (base_mask << off_q);
                if (i_dmem_ready) begin
                    state_nxt = is_load_q ? WAIT : IDLE;
                end
            end
            WAIT: begin
                if (i_dmem_rvalid) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= IDLE;
            addr_q           <= '0;
            wdata_q          <= '0;
            f3_q             <= 3'b000;
            is_load_q        <= 1'b0;
            rw_q             <= 1'b0;
            rd_q             <= 5'd0;
            pc_q             <= '0;
            o_WB_valid       <= 1'b0;
            o_WB_RegWrite    <= 1'b0;
            o_WB_reg_wr_addr <= 5'd0;
            o_WB_reg_wr_data <= '0;
            o_WB_pc          <= '0;
`ifdef YSYX_22040386_MEM_MISALIGN_CHK_EN
            o_WB_misalign    <= 1'b0;
`endif
        end else begin
            state      <= state_nxt;
            o_WB_valid <= 1'b0;
`ifdef YSYX_22040386_MEM_MISALIGN_CHK_EN
            o_WB_misalign <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (!is_mem_in) begin
                            o_WB_valid       <= 1'b1;
                            o_WB_RegWrite    <= i_MEM_RegWrite;
                            o_WB_reg_wr_addr <= i_MEM_reg_wr_addr;
                            o_WB_reg_wr_data <= i_MEM_reg_wr_data;
                            o_WB_pc          <= i_MEM_pc;
                        end else if (mis_in) begin
                            // Retired without touching memory and without a register write.
                            o_WB_valid       <= 1'b1;
                            o_WB_RegWrite    <= 1'b0;
                            o_WB_reg_wr_addr <= i_MEM_reg_wr_addr;
                            o_WB_reg_wr_data <= '0;
                            o_WB_pc          <= i_MEM_pc;
`ifdef YSYX_22040386_MEM_MISALIGN_CHK_EN
                            o_WB_misalign    <= 1'b1;
`endif
                        end else begin
                            addr_q    <= i_MEM_ALUresult;
                            wdata_q   <= i_MEM_mem_wr_data;
                            f3_q      <= i_MEM_FUNCT3;
                            // A bundle with both MemRead and MemWrite is a load.
                            is_load_q <= i_MEM_MemRead;
                            rw_q      <= i_MEM_RegWrite;
                            rd_q      <= i_MEM_reg_wr_addr;
                            pc_q      <= i_MEM_pc;
                        end
                    end
                end
                REQ: begin
                    if (i_dmem_ready && !is_load_q) begin
                        o_WB_valid       <= 1'b1;
                        o_WB_RegWrite    <= 1'b0;
                        o_WB_reg_wr_addr <= rd_q;
                        o_WB_reg_wr_data <= '0;
                        o_WB_pc          <= pc_q;
                    end
                end
                WAIT: begin
                    if (i_dmem_rvalid) begin
                        o_WB_valid       <= 1'b1;
                        o_WB_RegWrite    <= rw_q;
                        o_WB_reg_wr_addr <= rd_q;
                        o_WB_reg_wr_data <= load_extract(i_dmem_rdata, off_q, f3_q);
                        o_WB_pc          <= pc_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22040386_mem_stage.sv
// Testbench for ysyx_22040386_mem_stage: directed vector table, hand-written reset/throughput
// sequences and randomized ops against a byte-level memory model.
// Inputs are driven and outputs sampled on the falling edge of clk.
module tb_ysyx_22040386_mem_stage;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        i_MEM_valid;
    logic        o_MEM_ready;
    logic [63:0] i_MEM_ALUresult, i_MEM_reg_wr_data, i_MEM_mem_wr_data, i_MEM_pc;
    logic [2:0]  i_MEM_FUNCT3;
    logic        i_MEM_MemRead, i_MEM_MemWrite, i_MEM_RegWrite;
    logic [4:0]  i_MEM_reg_wr_addr;
    logic        o_dmem_req, i_dmem_ready, o_dmem_we, i_dmem_rvalid;
    logic [63:0] o_dmem_addr, o_dmem_wdata, i_dmem_rdata;
    logic [7:0]  o_dmem_wmask;
    logic        o_WB_valid, o_WB_RegWrite;
    logic [4:0]  o_WB_reg_wr_addr;
    logic [63:0] o_WB_reg_wr_data, o_WB_pc;
`ifdef YSYX_22040386_MEM_MISALIGN_CHK_EN
    logic        o_WB_misalign;
`endif

    ysyx_22040386_mem_stage #(.XLEN(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_MEM_valid(i_MEM_valid), .o_MEM_ready(o_MEM_ready),
        .i_MEM_ALUresult(i_MEM_ALUresult), .i_MEM_reg_wr_data(i_MEM_reg_wr_data),
        .i_MEM_mem_wr_data(i_MEM_mem_wr_data), .i_MEM_FUNCT3(i_MEM_FUNCT3),
        .i_MEM_MemRead(i_MEM_MemRead), .i_MEM_MemWrite(i_MEM_MemWrite),
        .i_MEM_RegWrite(i_MEM_RegWrite), .i_MEM_reg_wr_addr(i_MEM_reg_wr_addr),
        .i_MEM_pc(i_MEM_pc),
        .o_dmem_req(o_dmem_req), .i_dmem_ready(i_dmem_ready), .o_dmem_we(o_dmem_we),
        .o_dmem_addr(o_dmem_addr), .o_dmem_wdata(o_dmem_wdata), .o_dmem_wmask(o_dmem_wmask),
        .i_dmem_rvalid(i_dmem_rvalid), .i_dmem_rdata(i_dmem_rdata),
`ifdef YSYX_22040386_MEM_MISALIGN_CHK_EN
        .o_WB_misalign(o_WB_misalign),
`endif
        .o_WB_valid(o_WB_valid), .o_WB_RegWrite(o_WB_RegWrite),
        .o_WB_reg_wr_addr(o_WB_reg_wr_addr), .o_WB_reg_wr_data(o_WB_reg_wr_data),
        .o_WB_pc(o_WB_pc)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        mr, mw, rw;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [63:0] addr, regdata, wdata, rdata;
        int          rdy_dly, rv_dly;
        logic        mis;
        logic [63:0] e_addr;
        logic [7:0]  e_mask;
        logic [63:0] e_wdata, e_wbdata;
        logic        e_wbwe;
    } vec_t;

    // ---------------- reference model (byte-level) ----------------
    function automatic logic [7:0] m_mask(input logic [2:0] f3, input int off);
        logic [7:0] m;
        int sz;
        m  = 8'h00;
        sz = 1 << f3[1:0];
        for (int i = 0; i < sz; i++) if (off + i < 8) m[off+i] = 1'b1;
        return m;
    endfunction

    function automatic logic [63:0] m_wdata(input logic [63:0] w, input int off);
        logic [63:0] r;
        r = 64'h0;
        for (int i = 0; i < 8; i++) if (i >= off) r[8*i +: 8] = w[8*(i-off) +: 8];
        return r;
    endfunction

    function automatic logic [63:0] m_load(input logic [63:0] r, input int off, input logic [2:0] f3);
        logic [63:0] v;
        int n;
        v = 64'h0;
        if (f3 == 3'b111) return 64'h0;
        n = 1 << f3[1:0];
        for (int i = 0; i < n; i++) if (off + i < 8) v[8*i +: 8] = r[8*(off+i) +: 8];
        if (!f3[2] && n < 8 && v[8*n-1]) for (int b = 8*n; b < 64; b++) v[b] = 1'b1;
        return v;
    endfunction

    function automatic logic m_mis(input logic [2:0] f3, input int off);
        int n;
        if (f3 == 3'b111) return 1'b0;
        n = 1 << f3[1:0];
        return (off % n) != 0;
    endfunction

    task automatic idle_inputs();
        i_MEM_valid = 0; i_MEM_ALUresult = 0; i_MEM_reg_wr_data = 0; i_MEM_mem_wr_data = 0;
        i_MEM_pc = 0; i_MEM_FUNCT3 = 0; i_MEM_MemRead = 0; i_MEM_MemWrite = 0;
        i_MEM_RegWrite = 0; i_MEM_reg_wr_addr = 0; i_dmem_ready = 0; i_dmem_rvalid = 0;
        i_dmem_rdata = 0;
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, " ready"},    o_MEM_ready, 1);
        chk({tag, " req"},      o_dmem_req, 0);
        chk({tag, " we"},       o_dmem_we, 0);
        chk({tag, " addr"},     o_dmem_addr, 0);
        chk({tag, " wdata"},    o_dmem_wdata, 0);
        chk({tag, " wmask"},    o_dmem_wmask, 0);
        chk({tag, " wb_vld"},   o_WB_valid, 0);
        chk({tag, " wb_we"},    o_WB_RegWrite, 0);
        chk({tag, " wb_rd"},    o_WB_reg_wr_addr, 0);
        chk({tag, " wb_data"},  o_WB_reg_wr_data, 0);
        chk({tag, " wb_pc"},    o_WB_pc, 0);
`ifdef YSYX_22040386_MEM_MISALIGN_CHK_EN
        chk({tag, " wb_mis"},   o_WB_misalign, 0);
`endif
    endtask

    // Runs one op from a falling edge with the stage idle; returns at a falling edge.
    task automatic do_op(input string tag, input vec_t v, input logic [63:0] pc);
        logic is_mem;
        is_mem = v.mr || v.mw;
        chk({tag, " ready_pre"}, o_MEM_ready, 1);
        i_MEM_valid = 1; i_MEM_ALUresult = v.addr; i_MEM_reg_wr_data = v.regdata;
        i_MEM_mem_wr_data = v.wdata; i_MEM_FUNCT3 = v.f3; i_MEM_MemRead = v.mr;
        i_MEM_MemWrite = v.mw; i_MEM_RegWrite = v.rw; i_MEM_reg_wr_addr = v.rd; i_MEM_pc = pc;
        @(negedge clk);
        i_MEM_valid = 0;
        i_MEM_ALUresult = {$urandom, $urandom};
        i_MEM_mem_wr_data = {$urandom, $urandom};
        if (!is_mem) begin
            chk({tag, " wb_vld"},  o_WB_valid, 1);
            chk({tag, " wb_we"},   o_WB_RegWrite, v.e_wbwe);
            chk({tag, " wb_rd"},   o_WB_reg_wr_addr, v.rd);
            chk({tag, " wb_data"}, o_WB_reg_wr_data, v.e_wbdata);
            chk({tag, " wb_pc"},   o_WB_pc, pc);
            chk({tag, " no_req"},  o_dmem_req, 0);
        end
`ifdef YSYX_22040386_MEM_MISALIGN_CHK_EN
        else if (v.mis) begin
            chk({tag, " mis_vld"}, o_WB_valid, 1);
            chk({tag, " mis_we"},  o_WB_RegWrite, 0);
            chk({tag, " mis_flag"}, o_WB_misalign, 1);
            chk({tag, " mis_pc"},  o_WB_pc, pc);
            chk({tag, " mis_req"}, o_dmem_req, 0);
            chk({tag, " mis_rdy"}, o_MEM_ready, 1);
        end
`endif
        else begin
            chk({tag, " req"},   o_dmem_req, 1);
            chk({tag, " busy"},  o_MEM_ready, 0);
            chk({tag, " we"},    o_dmem_we, !v.mr);
            chk({tag, " addr"},  o_dmem_addr, v.e_addr);
            chk({tag, " wmask"}, o_dmem_wmask, v.e_mask);
            if (!v.mr) chk({tag, " wdata"}, o_dmem_wdata, v.e_wdata);
            for (int k = 0; k < v.rdy_dly; k++) begin
                // A stray rvalid while the request is pending must be ignored.
                i_dmem_rvalid = 1; i_dmem_rdata = {$urandom, $urandom};
                @(negedge clk);
                i_dmem_rvalid = 0;
                chk({tag, " req_hold"},  o_dmem_req, 1);
                chk({tag, " addr_hold"}, o_dmem_addr, v.e_addr);
                chk({tag, " busy_hold"}, o_MEM_ready, 0);
            end
            i_dmem_ready = 1;
            @(negedge clk);
            i_dmem_ready = 0;
            if (!v.mr) begin
                chk({tag, " st_vld"}, o_WB_valid, 1);
                chk({tag, " st_we"},  o_WB_RegWrite, 0);
                chk({tag, " st_rd"},  o_WB_reg_wr_addr, v.rd);
                chk({tag, " st_pc"},  o_WB_pc, pc);
            end else begin
                chk({tag, " wait_req"}, o_dmem_req, 0);
                for (int k = 0; k < v.rv_dly; k++) begin
                    i_dmem_rdata = {$urandom, $urandom};
                    @(negedge clk);
                    chk({tag, " wait_vld"}, o_WB_valid, 0);
                    chk({tag, " wait_busy"}, o_MEM_ready, 0);
                end
                i_dmem_rdata = v.rdata; i_dmem_rvalid = 1;
                @(negedge clk);
                i_dmem_rvalid = 0; i_dmem_rdata = {$urandom, $urandom};
                chk({tag, " ld_vld"},  o_WB_valid, 1);
                chk({tag, " ld_we"},   o_WB_RegWrite, v.rw);
                chk({tag, " ld_rd"},   o_WB_reg_wr_addr, v.rd);
                chk({tag, " ld_data"}, o_WB_reg_wr_data, v.e_wbdata);
                chk({tag, " ld_pc"},   o_WB_pc, pc);
            end
        end
        @(negedge clk);
        chk({tag, " pulse_end"}, o_WB_valid, 0);
        chk({tag, " ready_post"}, o_MEM_ready, 1);
`ifdef YSYX_22040386_MEM_MISALIGN_CHK_EN
        chk({tag, " mis_end"}, o_WB_misalign, 0);
`endif
    endtask

    function automatic vec_t mkv(input logic mr, mw, rw, input logic [2:0] f3, input logic [4:0] rd,
                                 input logic [63:0] addr, regdata, wdata, rdata,
                                 input int rdy_dly, rv_dly, input logic mis,
                                 input logic [63:0] e_addr, input logic [7:0] e_mask,
                                 input logic [63:0] e_wdata, e_wbdata, input logic e_wbwe);
        vec_t v;
        v.mr = mr; v.mw = mw; v.rw = rw; v.f3 = f3; v.rd = rd; v.addr = addr;
        v.regdata = regdata; v.wdata = wdata; v.rdata = rdata; v.rdy_dly = rdy_dly;
        v.rv_dly = rv_dly; v.mis = mis; v.e_addr = e_addr; v.e_mask = e_mask;
        v.e_wdata = e_wdata; v.e_wbdata = e_wbdata; v.e_wbwe = e_wbwe;
        return v;
    endfunction

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    vec_t        tbl[$];
    logic [63:0] mem[16];

    initial begin
        vec_t v;
        int   off, idx, kind;
        idle_inputs();
        rst_n = 0;
        repeat (2) @(negedge clk);
        chk_reset_outs("reset");
        rst_n = 1;

        //            mr mw rw f3    rd  addr                  regdata           wdata                  rdata                  rdy rv mis e_addr            e_mask e_wdata                e_wbdata               we
        tbl.push_back(mkv(0, 0, 1, 3'd0, 5,  64'h55,               64'h1234,         64'h0,                 64'h0,                 0, 0, 0, 64'h0,            8'h00, 64'h0,                 64'h1234,              1));
        tbl.push_back(mkv(0, 1, 1, 3'd0, 3,  64'h8000_0003,        64'h0,            64'hAB,                64'h0,                 2, 0, 0, 64'h8000_0000,    8'h08, 64'hAB00_0000,         64'h0,                 0));
        tbl.push_back(mkv(1, 0, 1, 3'd0, 7,  64'h8000_0006,        64'h0,            64'h0,                 64'h0080_0000_0000_0000, 0, 0, 0, 64'h8000_0000,  8'h00, 64'h0,                 64'hFFFF_FFFF_FFFF_FF80, 1));
        tbl.push_back(mkv(1, 0, 1, 3'd4, 7,  64'h8000_0006,        64'h0,            64'h0,                 64'h0080_0000_0000_0000, 0, 0, 0, 64'h8000_0000,  8'h00, 64'h0,                 64'h80,                1));
        tbl.push_back(mkv(1, 0, 1, 3'd2, 9,  64'h8000_0004,        64'h0,            64'h0,                 64'h8765_4321_0000_0000, 0, 5, 0, 64'h8000_0000,  8'h00, 64'h0,                 64'hFFFF_FFFF_8765_4321, 1));
        tbl.push_back(mkv(0, 1, 0, 3'd3, 2,  64'h8000_0010,        64'h0,            64'h1122_3344_5566_7788, 64'h0,               1, 0, 0, 64'h8000_0010,    8'hFF, 64'h1122_3344_5566_7788, 64'h0,               0));
        tbl.push_back(mkv(0, 1, 1, 3'd1, 4,  64'h8000_0007,        64'h0,            64'hBEEF,              64'h0,                 0, 0, 1, 64'h8000_0000,    8'h80, 64'hEF00_0000_0000_0000, 64'h0,               0));
        tbl.push_back(mkv(1, 1, 1, 3'd3, 10, 64'h8000_0008,        64'h0,            64'h0,                 64'hDEAD_BEEF_CAFE_F00D, 1, 1, 0, 64'h8000_0008,  8'h00, 64'h0,                 64'hDEAD_BEEF_CAFE_F00D, 1));
        tbl.push_back(mkv(1, 0, 1, 3'd5, 11, 64'h8000_0002,        64'h0,            64'h0,                 64'h0000_0000_F00D_0000, 0, 2, 0, 64'h8000_0000,  8'h00, 64'h0,                 64'hF00D,              1));
        tbl.push_back(mkv(1, 0, 1, 3'd1, 12, 64'h8000_0002,        64'h0,            64'h0,                 64'h0000_0000_F00D_0000, 3, 0, 0, 64'h8000_0000,  8'h00, 64'h0,                 64'hFFFF_FFFF_FFFF_F00D, 1));
        tbl.push_back(mkv(1, 0, 1, 3'd7, 13, 64'h8000_0000,        64'h0,            64'h0,                 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 64'h8000_0000,  8'h00, 64'h0,                 64'h0,                 1));
        tbl.push_back(mkv(1, 0, 1, 3'd6, 14, 64'h8000_0005,        64'h0,            64'h0,                 64'h1122_3344_5566_7788, 0, 0, 1, 64'h8000_0000,  8'h00, 64'h0,                 64'h0011_2233,         1));
        tbl.push_back(mkv(1, 0, 1, 3'd3, 15, 64'h8000_0024,        64'h0,            64'h0,                 64'hAAAA_BBBB_CCCC_DDDD, 0, 0, 1, 64'h8000_0020,  8'h00, 64'h0,                 64'hAAAA_BBBB,         1));
        tbl.push_back(mkv(0, 0, 0, 3'd0, 31, 64'h0,                64'hFFFF_FFFF_FFFF_FFFF, 64'h0,          64'h0,                 0, 0, 0, 64'h0,            8'h00, 64'h0,                 64'hFFFF_FFFF_FFFF_FFFF, 0));
        tbl.push_back(mkv(0, 1, 1, 3'd2, 6,  64'h8000_003C,        64'h0,            64'h1234_5678_9ABC_DEF0, 64'h0,               0, 0, 0, 64'h8000_0038,    8'hF0, 64'h9ABC_DEF0_0000_0000, 64'h0,               0));

        foreach (tbl[i]) do_op($sformatf("vec%0d", i), tbl[i], 64'h1000 + 64'(4 * i));

        // Back-to-back non-memory ops retire one per cycle.
        i_MEM_valid = 1; i_MEM_MemRead = 0; i_MEM_MemWrite = 0; i_MEM_RegWrite = 1;
        i_MEM_reg_wr_addr = 1; i_MEM_reg_wr_data = 64'hA1; i_MEM_pc = 64'h2000;
        @(negedge clk);
        chk("b2b first_vld", o_WB_valid, 1);
        chk("b2b first_data", o_WB_reg_wr_data, 64'hA1);
        chk("b2b ready", o_MEM_ready, 1);
        i_MEM_reg_wr_addr = 2; i_MEM_reg_wr_data = 64'hB2; i_MEM_pc = 64'h2004;
        @(negedge clk);
        i_MEM_valid = 0;
        chk("b2b second_vld", o_WB_valid, 1);
        chk("b2b second_rd", o_WB_reg_wr_addr, 2);
        chk("b2b second_data", o_WB_reg_wr_data, 64'hB2);
        @(negedge clk);
        chk("b2b idle_vld", o_WB_valid, 0);
        chk("b2b hold_data", o_WB_reg_wr_data, 64'hB2);

        // Reset while waiting for load data; the late rvalid must not retire anything.
        i_MEM_valid = 1; i_MEM_MemRead = 1; i_MEM_FUNCT3 = 3'd3; i_MEM_ALUresult = 64'h8000_0040;
        i_MEM_reg_wr_addr = 8;
        @(negedge clk);
        i_MEM_valid = 0; i_dmem_ready = 1;
        @(negedge clk);
        i_dmem_ready = 0;
        chk("rstwait in_wait", o_MEM_ready, 0);
        rst_n = 0;
        @(negedge clk);
        chk_reset_outs("rstwait");
        rst_n = 1;
        i_dmem_rvalid = 1; i_dmem_rdata = 64'h0123_4567_89AB_CDEF;
        @(negedge clk);
        i_dmem_rvalid = 0;
        chk("rstwait late_vld", o_WB_valid, 0);
        chk("rstwait late_data", o_WB_reg_wr_data, 0);
        chk("rstwait late_ready", o_MEM_ready, 1);
        @(negedge clk);
        chk("rstwait late_vld2", o_WB_valid, 0);
        idle_inputs();

        // Randomized ops against the memory model.
        for (int w = 0; w < 16; w++) mem[w] = {$urandom, $urandom};
        for (int n = 0; n < 200; n++) begin
            kind = $urandom_range(0, 3);
            v.addr    = 64'h8000_0000 + 64'($urandom_range(0, 127));
            off       = int'(v.addr[2:0]);
            idx       = int'(v.addr[6:3]);
            v.mr      = (kind == 1) || (kind == 3);
            v.mw      = (kind == 2) || (kind == 3);
            v.rw      = 1'($urandom_range(0, 1));
            v.rd      = 5'($urandom_range(0, 31));
            v.f3      = v.mw && !v.mr ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
            v.regdata = {$urandom, $urandom};
            v.wdata   = {$urandom, $urandom};
            v.rdy_dly = $urandom_range(0, 3);
            v.rv_dly  = $urandom_range(0, 3);
            v.mis     = (v.mr || v.mw) && m_mis(v.f3, off);
            v.rdata   = mem[idx];
            v.e_addr  = {v.addr[63:3], 3'b000};
            v.e_mask  = v.mr ? 8'h00 : m_mask(v.f3, off);
            v.e_wdata = m_wdata(v.wdata, off);
            v.e_wbdata = (kind == 0) ? v.regdata : m_load(v.rdata, off, v.f3);
            v.e_wbwe  = (kind == 0) ? v.rw : 1'b0;
            do_op($sformatf("rnd%0d", n), v, {$urandom, $urandom});
            if (v.mw && !v.mr) begin
`ifdef YSYX_22040386_MEM_MISALIGN_CHK_EN
                if (!v.mis)
`endif
                for (int b = 0; b < 8; b++) if (v.e_mask[b]) mem[idx][8*b +: 8] = v.e_wdata[8*b +: 8];
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
